// File: rtl/animation_draw_car.sv
// animation_draw_car
// Plots the 15x15 car sprite for one heading at (iX,iY) on the shared VGA
// plot bus. Each pixel takes three cycles: ADDR presents the sprite ROM
// address, WAIT covers the second cycle of ROM latency, and PLOT forwards the
// ROM data with the clipped write strobe. Transparent and off-screen pixels
// are skipped, so the background restored by the erase path shows through.
module animation_draw_car #(
   parameter int         SPRITE_W    = 15,
   parameter int         SPRITE_H    = 15,
   parameter int         SCREEN_W    = 160,
   parameter int         SCREEN_H    = 120,
   parameter logic [8:0] TRANSPARENT = 9'h1FF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iDrawCar,
   input  logic [7:0]  iX,
   input  logic [6:0]  iY,
   input  logic [2:0]  iDir,
   input  logic [8:0]  iRomQ,
   output logic [10:0] oRomAddr,
   output logic [7:0]  oX,
   output logic [6:0]  oY,
   output logic [8:0]  oColour,
   output logic        oPlot,
   output logic        oBusy,
   output logic        oDrawDone
);

   // One sprite frame occupies SPRITE_W*SPRITE_H consecutive ROM words.
   localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;

   localparam logic [3:0] LAST_COL = 4'(SPRITE_W - 1);
   localparam logic [3:0] LAST_ROW = 4'(SPRITE_H - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_PLOT = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   // First ROM word of the frame for a given heading.
   function automatic logic [10:0] frame_base(input logic [2:0] dir);
      frame_base = 11'(dir) * 11'(FRAME_WORDS);
   endfunction

   logic [2:0]  r_state;
   logic [2:0]  w_state_next;
   logic [7:0]  r_x;
   logic [6:0]  r_y;
   logic [2:0]  r_dir;
   logic [3:0]  r_row;
   logic [3:0]  r_col;
   logic [10:0] r_addr;
   logic        w_last_col;
   logic        w_last_pixel;
   logic [8:0]  w_sum_x;
   logic [7:0]  w_sum_y;
   logic        w_on_screen;

   // The row/col pair walks the sprite in raster order; r_addr advances by
   // one word per pixel, which matches dir*225 + row*15 + col without any
   // multiply by row or divide back into row/col.
   assign w_last_col   = (r_col == LAST_COL);
   assign w_last_pixel = w_last_col && (r_row == LAST_ROW);

   // Sums are one bit wider than the ports so a sprite hanging past the
   // right or bottom edge is clipped instead of wrapping to the other side.
   assign w_sum_x     = {1'b0, r_x} + {5'b0, r_col};
   assign w_sum_y     = {1'b0, r_y} + {4'b0, r_row};
   assign w_on_screen = (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 8'(SCREEN_H));

   // Next-state decode for the per-pixel ADDR/WAIT/PLOT sequence.
   always_comb begin
      w_state_next = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (iDrawCar) begin
               w_state_next = S_LOAD;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_LOAD: w_state_next = S_ADDR;
         S_ADDR: w_state_next = S_WAIT;
         S_WAIT: w_state_next = S_PLOT;
         S_PLOT: begin
            if (w_last_pixel) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_ADDR;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Capture position and heading at start so later input changes cannot
   // disturb a draw in progress.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_x   <= 8'd0;
         r_y   <= 7'd0;
         r_dir <= 3'd0;
      end else if ((r_state == S_IDLE) && iDrawCar) begin
         r_x   <= iX;
         r_y   <= iY;
         r_dir <= iDir;
      end else begin
         r_x   <= r_x;
         r_y   <= r_y;
         r_dir <= r_dir;
      end
   end

   // Pixel counters and ROM address: cleared/seeded in LOAD, stepped as
   // each PLOT cycle finishes.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_row  <= 4'd0;
         r_col  <= 4'd0;
         r_addr <= 11'd0;
      end else begin
         case (r_state)
            S_LOAD: begin
               r_row  <= 4'd0;
               r_col  <= 4'd0;
               r_addr <= frame_base(r_dir);
            end
            S_PLOT: begin
               if (w_last_col) begin
                  r_col <= 4'd0;
                  r_row <= r_row + 4'd1;
               end else begin
                  r_col <= r_col + 4'd1;
                  r_row <= r_row;
               end
               r_addr <= r_addr + 11'd1;
            end
            default: begin
               r_row  <= r_row;
               r_col  <= r_col;
               r_addr <= r_addr;
            end
         endcase
      end
   end

   // Output decode: the plot bus is quiet outside PLOT so the top-level mux
   // can OR or select between drawers freely; ROM data is forwarded in the
   // cycle it becomes valid.
   always_comb begin
      oRomAddr  = 11'd0;
      oX        = 8'd0;
      oY        = 7'd0;
      oColour   = 9'd0;
      oPlot     = 1'b0;
      oDrawDone = 1'b0;
      case (r_state)
         S_ADDR: begin
            oRomAddr = r_addr;
         end
         S_WAIT: begin
            oRomAddr = r_addr;
         end
         S_PLOT: begin
            oRomAddr = r_addr;
            oX       = w_sum_x[7:0];
            oY       = w_sum_y[6:0];
            oColour  = iRomQ;
            oPlot    = (iRomQ != TRANSPARENT) && w_on_screen;
         end
         S_DONE: begin
            oDrawDone = 1'b1;
         end
         default: begin
            oDrawDone = 1'b0;
         end
      endcase
   end

   assign oBusy = (r_state != S_IDLE);

endmodule

// File: tb/tb_animation_draw_car.sv
// tb_animation_draw_car
// Directed bench for the car sprite drawer. A two-stage ROM model feeds
// iRomQ; each draw is walked cycle by cycle against an independent timing
// model (pixel k: ADDR at E(1+3k), PLOT at E(3+3k), DONE at E676), and
// per-draw statistics are compared to hand-computed values.
module tb_animation_draw_car;

   logic        clk;
   logic        resetn;
   logic        i_draw;
   logic [7:0]  i_x;
   logic [6:0]  i_y;
   logic [2:0]  i_dir;
   logic [8:0]  i_rom_q;
   logic [10:0] o_rom_addr;
   logic [7:0]  o_x;
   logic [6:0]  o_y;
   logic [8:0]  o_colour;
   logic        o_plot;
   logic        o_busy;
   logic        o_draw_done;

   int n_checks = 0;
   int n_fail   = 0;
   int rom_mode = 0;

   // per-draw statistics gathered from the DUT outputs
   int st_plots, st_first_x, st_first_y, st_last_x, st_last_y;
   int st_min_x, st_max_x, st_min_y, st_max_y;
   int st_done_at, st_done_cnt, st_err, st_addr_first, st_addr_last;

   logic [8:0] rom_p1;

   animation_draw_car dut (
      .clk       (clk),
      .resetn    (resetn),
      .iDrawCar  (i_draw),
      .iX        (i_x),
      .iY        (i_y),
      .iDir      (i_dir),
      .iRomQ     (i_rom_q),
      .oRomAddr  (o_rom_addr),
      .oX        (o_x),
      .oY        (o_y),
      .oColour   (o_colour),
      .oPlot     (o_plot),
      .oBusy     (o_busy),
      .oDrawDone (o_draw_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // sprite ROM contents selected by rom_mode
   function automatic int rom_data(input int addr, input int mode);
      int p;
      int col;
      int v;
      p   = addr % 225;
      col = p % 15;
      case (mode)
         0: rom_data = 'h0E0;
         1: rom_data = (col < 5) ? 'h1FF : 'h007;
         default: begin
            v = (addr * 7) & 511;
            if (v == 511) v = 0;
            rom_data = v;
         end
      endcase
   endfunction

   // two-cycle ROM latency
   always @(posedge clk) begin
      rom_p1  <= 9'(rom_data(int'(o_rom_addr), rom_mode));
      i_rom_q <= rom_p1;
   end

   task automatic check(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Start a draw and follow it sample by sample (sample s is taken at the
   // negedge after edge Es, E0 being the edge that sees iDrawCar).
   task automatic run_draw(input int x, input int y, input int d,
                           input int pulse_at, input int reset_at, input bit hold);
      int p, ph, row, col;
      int e_addr, e_x, e_y, e_c, e_plot, e_busy, e_done;
      st_plots = 0; st_first_x = -1; st_first_y = -1; st_last_x = -1; st_last_y = -1;
      st_min_x = 999; st_max_x = -1; st_min_y = 999; st_max_y = -1;
      st_done_at = -1; st_done_cnt = 0; st_err = 0; st_addr_first = -1; st_addr_last = -1;
      @(negedge clk);
      i_x = 8'(x); i_y = 7'(y); i_dir = 3'(d); i_draw = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) i_draw = 1'b0;
      i_x = ~8'(x); i_y = ~7'(y); i_dir = ~3'(d);
      for (int s = 0; s <= 677; s++) begin
         @(negedge clk);
         if (s == reset_at) begin
            check("reset_busy", int'(o_busy), 0);
            check("reset_plot", int'(o_plot), 0);
            check("reset_outs", int'(o_rom_addr) + int'(o_x) + int'(o_y) + int'(o_colour)
                                + int'(o_draw_done), 0);
            resetn = 1'b1;
            break;
         end
         e_addr = 0; e_x = 0; e_y = 0; e_c = 0; e_plot = 0; e_done = 0; e_busy = 1;
         if (s >= 1 && s <= 675) begin
            p = (s - 1) / 3; ph = (s - 1) % 3; row = p / 15; col = p % 15;
            e_addr = d * 225 + p;
            if (ph == 2) begin
               e_x = (x + col) % 256;
               e_y = (y + row) % 128;
               e_c = rom_data(e_addr, rom_mode);
               e_plot = (e_c != 511 && (x + col) < 160 && (y + row) < 120) ? 1 : 0;
            end
         end else if (s == 676) begin
            e_done = 1;
         end else if (s == 677) begin
            e_busy = 0;
         end
         if (int'(o_rom_addr) != e_addr || int'(o_x) != e_x || int'(o_y) != e_y ||
             int'(o_colour) != e_c || int'(o_plot) != e_plot || int'(o_busy) != e_busy ||
             int'(o_draw_done) != e_done)
            st_err++;
         if (s == 1)   st_addr_first = int'(o_rom_addr);
         if (s == 675) st_addr_last  = int'(o_rom_addr);
         if (o_plot) begin
            st_plots++;
            if (st_first_x < 0) begin st_first_x = int'(o_x); st_first_y = int'(o_y); end
            st_last_x = int'(o_x); st_last_y = int'(o_y);
            if (int'(o_x) < st_min_x) st_min_x = int'(o_x);
            if (int'(o_x) > st_max_x) st_max_x = int'(o_x);
            if (int'(o_y) < st_min_y) st_min_y = int'(o_y);
            if (int'(o_y) > st_max_y) st_max_y = int'(o_y);
         end
         if (o_draw_done) begin
            st_done_cnt++;
            if (st_done_at < 0) st_done_at = s;
         end
         if (s == pulse_at - 1) begin i_draw = 1'b1; i_x = 8'd99; end
         if (s == pulse_at)     i_draw = 1'b0;
         if (s == reset_at - 1) resetn = 1'b0;
      end
   endtask

   initial begin
      resetn = 1'b0; i_draw = 1'b0; i_x = 8'd0; i_y = 7'd0; i_dir = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(o_busy), 0);
      check("rst_outs", int'(o_rom_addr) + int'(o_x) + int'(o_y) + int'(o_colour)
                        + int'(o_plot) + int'(o_draw_done), 0);
      resetn = 1'b1;

      // 1: opaque frame at (10,20)
      rom_mode = 0;
      run_draw(10, 20, 0, -1, -1, 1'b0);
      check("t1_model", st_err, 0);
      check("t1_plots", st_plots, 225);
      check("t1_first_x", st_first_x, 10);
      check("t1_first_y", st_first_y, 20);
      check("t1_last_x", st_last_x, 24);
      check("t1_last_y", st_last_y, 34);
      check("t1_done_at", st_done_at, 676);
      check("t1_done_cnt", st_done_cnt, 1);

      // 2: transparent left columns
      rom_mode = 1;
      run_draw(10, 20, 0, -1, -1, 1'b0);
      check("t2_model", st_err, 0);
      check("t2_plots", st_plots, 150);
      check("t2_min_x", st_min_x, 15);
      check("t2_done_at", st_done_at, 676);

      // 3: clipped at bottom-right corner
      rom_mode = 0;
      run_draw(150, 110, 0, -1, -1, 1'b0);
      check("t3_model", st_err, 0);
      check("t3_plots", st_plots, 100);
      check("t3_min_x", st_min_x, 150);
      check("t3_max_x", st_max_x, 159);
      check("t3_min_y", st_min_y, 110);
      check("t3_max_y", st_max_y, 119);
      check("t3_addr_first", st_addr_first, 0);

      // 4: heading 7 address range, varying colours
      rom_mode = 2;
      run_draw(40, 50, 7, -1, -1, 1'b0);
      check("t4_model", st_err, 0);
      check("t4_addr_first", st_addr_first, 1575);
      check("t4_addr_last", st_addr_last, 1799);

      // 5: second start request while busy is ignored
      rom_mode = 0;
      run_draw(30, 40, 2, 100, -1, 1'b0);
      check("t5_model", st_err, 0);
      check("t5_first_x", st_first_x, 30);
      check("t5_done_cnt", st_done_cnt, 1);

      // 6: reset mid-draw, then a fresh draw
      run_draw(30, 40, 1, -1, 300, 1'b0);
      run_draw(5, 6, 3, -1, -1, 1'b0);
      check("t6_model", st_err, 0);
      check("t6_plots", st_plots, 225);
      check("t6_done_at", st_done_at, 676);

      // 7: request held high restarts from the following IDLE
      run_draw(5, 6, 0, -1, -1, 1'b1);
      check("t7_model", st_err, 0);
      @(negedge clk);
      check("t7_restart_busy", int'(o_busy), 1);
      i_draw = 1'b0;
      resetn = 1'b0;
      @(negedge clk);
      check("t7_reset_busy", int'(o_busy), 0);
      resetn = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
